// File: rtl/ram_pattern_filler.sv
// Purpose : fills DEPTH words of RAM port B with a selectable pattern, optionally reads back and verifies.
// Latency : done at cycle DEPTH+1 (fill only) or 2*DEPTH+RD_LAT+1 (fill + verify) after start is accepted.
// Backpr. : none; RAM port B accepts one access per cycle, start is ignored while busy_o=1.
//
// Ports:
//   clk_i, rst_i              clock and synchronous active-high reset
//   start_i                   one-cycle request, accepted only in IDLE
//   mode_i, seed_i            pattern select and seed, latched at start
//   verify_en_i               enable readback pass, latched at start
//   busy_o, done_o, pass_o    status; pass_o held until next accepted start
//   err_count_o               saturating mismatch count
//   first_err_addr_o          address of first mismatch, 0 if none
//   data_b_o/addr_b_o/we_b_o  RAM port-B write data / address / write enable
//   q_b_i                     RAM port-B read data, RD_LAT cycles after addr_b_o
module ram_pattern_filler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic [7:0]        seed_i,
  input  logic              verify_en_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [15:0]       err_count_o,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [DATA_W-1:0] data_b_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic              we_b_o,
  input  logic [DATA_W-1:0] q_b_i
);

  typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_VERIFY, ST_DRAIN, ST_FIN} state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [7:0] s,
                                            input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] rep;
    logic [DATA_W-1:0] w;
    logic [7:0]        c;
    rep = {(DATA_W/8){s}};
    c   = s + 8'(a);  // 8-bit wrap intended
    w   = '0;
    case (m)
      2'd0: w = rep;
      2'd1: w[31:0] = {c, 6'b111010, c + 8'd1, 10'b1110100000};
      2'd2: w[ADDR_W-1:0] = a;
      default: begin
        w[ADDR_W-1:0] = ~a;
        w = w ^ rep;
      end
    endcase
    return w;
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          drain_q, drain_d;
  logic [1:0]          mode_q, mode_d;
  logic [7:0]          seed_q, seed_d;
  logic                verify_q, verify_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d, we_q, we_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d, addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  // Read-address delay line: stage RD_LAT-1 lines up with q_b_i for that address.
  logic                dl_vld_q  [RD_LAT];
  logic [ADDR_W-1:0]   dl_addr_q [RD_LAT];

  logic start_acc;
  assign start_acc = (state_q == ST_IDLE) && start_i;

  // State register (plus all other flops).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;  drain_q <= '0;
      mode_q <= '0; seed_q <= '0; verify_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; pass_q <= 1'b0; we_q <= 1'b0;
      err_q <= '0; first_q <= '0; addr_q <= '0; data_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dl_vld_q[i]  <= 1'b0;
        dl_addr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;  drain_q <= drain_d;
      mode_q <= mode_d; seed_q <= seed_d; verify_q <= verify_d;
      busy_q <= busy_d; done_q <= done_d; pass_q <= pass_d; we_q <= we_d;
      err_q <= err_d; first_q <= first_d; addr_q <= addr_d; data_q <= data_d;
      dl_vld_q[0]  <= (state_q == ST_VERIFY);
      dl_addr_q[0] <= cnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        dl_vld_q[i]  <= dl_vld_q[i-1];
        dl_addr_q[i] <= dl_addr_q[i-1];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start_i) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          state_d = verify_q ? ST_VERIFY : ST_FIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_VERIFY: begin
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = ST_FIN;
        else                       drain_d = drain_q + 2'd1;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the next state.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    we_d   = (state_d == ST_FILL);
    addr_d = ((state_d == ST_FILL) || (state_d == ST_VERIFY)) ? cnt_d : '0;
    data_d = '0;
    // In IDLE the latches are loading this same edge, so take mode/seed from the inputs.
    if (state_d == ST_FILL)
      data_d = (state_q == ST_IDLE) ? pat(mode_i, seed_i, cnt_d) : pat(mode_q, seed_q, cnt_d);
  end

  // Latches and readback compare.
  logic cmp_err;
  assign cmp_err = dl_vld_q[RD_LAT-1] &&
                   (q_b_i != pat(mode_q, seed_q, dl_addr_q[RD_LAT-1]));

  always_comb begin
    mode_d   = mode_q;
    seed_d   = seed_q;
    verify_d = verify_q;
    err_d    = err_q;
    first_d  = first_q;
    pass_d   = pass_q;
    if (start_acc) begin
      mode_d   = mode_i;
      seed_d   = seed_i;
      verify_d = verify_en_i;
      err_d    = '0;
      first_d  = '0;
      pass_d   = 1'b0;
    end else begin
      if (cmp_err) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0)    first_d = dl_addr_q[RD_LAT-1];
      end
      // The final compare lands on the same edge that enters FIN.
      if (state_d == ST_FIN) pass_d = (err_d == 16'd0);
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign data_b_o         = data_q;
  assign addr_b_o         = addr_q;
  assign we_b_o           = we_q;

endmodule

// File: tb/tb_ram_pattern_filler.sv
module tb_ram_pattern_filler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b1;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  seed = 8'd0;
  logic        verify_en = 1'b0;
  logic        busy, done, pass, we_b;
  logic [15:0] err_count;
  logic [11:0] first_err_addr, addr_b;
  logic [31:0] data_b, q_b;

  ram_pattern_filler #(.DATA_W(32), .ADDR_W(12), .DEPTH(16), .RD_LAT(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .seed_i(seed),
    .verify_en_i(verify_en), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .first_err_addr_o(first_err_addr),
    .data_b_o(data_b), .addr_b_o(addr_b), .we_b_o(we_b), .q_b_i(q_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural RAM, 2-cycle read latency, optional per-address read corruption.
  logic [31:0] mem [16];
  logic [31:0] rd_pipe [2];
  logic [15:0] corrupt = 16'h0;
  always @(posedge clk) begin
    if (we_b) mem[addr_b[3:0]] <= data_b;
    rd_pipe[0] <= mem[addr_b[3:0]] ^ (corrupt[addr_b[3:0]] ? 32'h0000_0100 : 32'h0);
    rd_pipe[1] <= rd_pipe[0];
  end
  assign q_b = rd_pipe[1];

  function automatic logic [31:0] tb_pat(input logic [1:0] m, input logic [7:0] s,
                                         input logic [11:0] a);
    logic [7:0] c;
    c = s + a[7:0];
    case (m)
      2'd0:    return {4{s}};
      2'd1:    return {c, 6'b111010, c + 8'd1, 10'b1110100000};
      2'd2:    return {20'd0, a};
      default: return {20'd0, ~a} ^ {4{s}};
    endcase
  endfunction

  typedef struct { logic [11:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  int done_cnt  = 0;
  int done_cyc  = 0;
  int done_base = 0;
  int start_cyc = 0;

  // Write monitor / scoreboard, plus idle-bus and range checks.
  always @(negedge clk) begin
    wr_t e;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    chk("addr_range", {63'd0, addr_b <= 12'd15}, 64'd1);
    if (we_b) begin
      if (sb.size() == 0) begin
        chk("wr_extra", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 64'(addr_b), 64'(e.addr));
        chk("wr_data", 64'(data_b), 64'(e.data));
      end
    end else begin
      chk("idle_data", 64'(data_b), 64'd0);
      if (!busy) chk("idle_addr", 64'(addr_b), 64'd0);
    end
  end

  task automatic start_op(input logic [1:0] m, input logic [7:0] s, input logic v);
    wr_t w;
    @(posedge clk); #1;
    mode = m; seed = s; verify_en = v; start = 1'b1;
    start_cyc = cyc;
    done_base = done_cnt;
    for (int a = 0; a < 16; a++) begin
      w.addr = 12'(a);
      w.data = tb_pat(m, s, 12'(a));
      sb.push_back(w);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_result(input int lat, input logic ep, input logic [15:0] ee,
                             input logic [11:0] ef);
    for (int i = 0; i < 300; i++) begin
      if (done_cnt != done_base) break;
      @(posedge clk);
    end
    @(negedge clk);
    chk("done_seen", 64'(done_cnt - done_base), 64'd1);
    chk("done_lat", 64'(done_cyc - start_cyc), 64'(lat));
    chk("pass", 64'(pass), 64'(ep));
    chk("err_count", 64'(err_count), 64'(ee));
    chk("first_err", 64'(first_err_addr), 64'(ef));
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  logic [1:0]  t_mode [6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
  logic [7:0]  t_seed [6] = '{8'h41, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hC3};
  logic        t_ver  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] t_cor  [6] = '{16'h0, 16'h0, 16'h0, 16'h0220, 16'h0, 16'h8001};

  initial begin
    int          ne;
    logic [11:0] nf;
    logic [31:0] w;

    // Reset with start held high: must be ignored.
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_first", 64'(first_err_addr), 64'd0);
    chk("rst_we", 64'(we_b), 64'd0);
    chk("rst_addr", 64'(addr_b), 64'd0);
    chk("rst_data", 64'(data_b), 64'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Pattern / verify table.
    for (int t = 0; t < 6; t++) begin
      corrupt = t_cor[t];
      ne = 0; nf = '0;
      if (t_ver[t]) begin
        for (int a = 15; a >= 0; a--) if (t_cor[t][a]) begin ne++; nf = 12'(a); end
      end
      start_op(t_mode[t], t_seed[t], t_ver[t]);
      wait_result(t_ver[t] ? 35 : 17, (ne == 0), 16'(ne), nf);
      if (t == 0) begin
        w = mem[3];
        chk("m1_word3", 64'(w), 64'({8'h44, 6'b111010, 8'h45, 10'b1110100000}));
      end
      if (t == 1) begin
        w = mem[0];
        chk("wrap_a0_c", 64'(w[31:24]), 64'hFF);
        chk("wrap_a0_c1", 64'(w[17:10]), 64'h00);
        w = mem[1];
        chk("wrap_a1_c", 64'(w[31:24]), 64'h00);
        chk("wrap_a1_c1", 64'(w[17:10]), 64'h01);
      end
    end
    corrupt = 16'h0;

    // Start during FILL must be ignored, no relatch, single done.
    start_op(2'd2, 8'h10, 1'b1);
    repeat (3) @(posedge clk);
    #1; mode = 2'd0; seed = 8'h99; verify_en = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_result(35, 1'b1, 16'd0, 12'd0);
    repeat (40) @(posedge clk);
    chk("one_done", 64'(done_cnt - done_base), 64'd1);

    // Reset in the middle of FILL.
    start_op(2'd2, 8'h00, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (we_b && addr_b == 12'd7) break;
    end
    chk("rst_hit_addr", 64'(addr_b), 64'd7);
    rst = 1'b1;
    @(posedge clk); #2;
    chk("abort_we", 64'(we_b), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    sb.delete();
    repeat (40) @(posedge clk);
    chk("abort_no_done", 64'(done_cnt - done_base), 64'd0);
    start_op(2'd2, 8'h00, 1'b1);
    wait_result(35, 1'b1, 16'd0, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
